// File: rtl/counter_ctrl_pkg.sv
// rtl/counter_ctrl_pkg.sv - state and mode encodings shared by counter_controller
package counter_ctrl_pkg;

   localparam int DEFAULT_WIDTH = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   localparam logic [1:0] MODE_UP_WRAP   = 2'b00;
   localparam logic [1:0] MODE_DOWN_WRAP = 2'b01;
   localparam logic [1:0] MODE_PINGPONG  = 2'b10;
   localparam logic [1:0] MODE_ONESHOT   = 2'b11;

endpackage

// File: rtl/counter_controller_tick_prescaler.sv
// rtl/counter_controller_tick_prescaler.sv - pacing divider, one TICK every DIV running cycles
module tick_prescaler #(
   parameter int DIV = 4
) (
   input  logic CLK,
   input  logic RESET,
   input  logic CLEAR,
   input  logic RUN,
   output logic TICK
);

   localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] TERM = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (CLEAR) begin
         cnt_d = '0;
      end else if (RUN) begin
         cnt_d = (cnt_q == TERM) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign TICK = RUN && (cnt_q == TERM);

endmodule

// File: rtl/counter_controller.sv
// rtl/counter_controller.sv - run-mode sequencer for the up/down counter datapath
// COUNTER_CTRL_EXT_TICK_EN replaces the prescaler with rising edges of EXT_TICK.
module counter_controller
   import counter_ctrl_pkg::*;
#(
   parameter int WIDTH    = DEFAULT_WIDTH,
   parameter int TICK_DIV = 100000
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             START,
   input  logic             STOP,
   input  logic [1:0]       MODE,
   input  logic [WIDTH-1:0] LIMIT_LO,
   input  logic [WIDTH-1:0] LIMIT_HI,
   input  logic [WIDTH-1:0] COUNT,
`ifdef COUNTER_CTRL_EXT_TICK_EN
   input  logic             EXT_TICK,
`endif
   output logic             COUNT_EN,
   output logic             COUNT_UP,
   output logic             COUNT_LOAD,
   output logic [WIDTH-1:0] LOAD_VALUE,
   output logic [1:0]       STATE,
   output logic             WRAP_PULSE,
   output logic             CFG_ERR
);

   state_e           state_q, state_d;
   logic [1:0]       mode_q, mode_d;
   logic             count_en_q, count_en_d;
   logic             count_up_q, count_up_d;
   logic             count_load_q, count_load_d;
   logic [WIDTH-1:0] load_value_q, load_value_d;
   logic             wrap_q, wrap_d;
   logic             cfg_err_q, cfg_err_d;

   logic             presc_run;
   logic             tick;
   logic             in_range;
   logic [WIDTH-1:0] start_val;

   // STOP wins over START, and also freezes the tick source in the same cycle.
   assign presc_run = (state_q == ST_RUN) && !STOP;
   assign in_range  = (COUNT >= LIMIT_LO) && (COUNT <= LIMIT_HI);
   assign start_val = (mode_q == MODE_DOWN_WRAP) ? LIMIT_HI : LIMIT_LO;

`ifdef COUNTER_CTRL_EXT_TICK_EN
   logic ext_q, ext_prev_q;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         ext_q      <= 1'b0;
         ext_prev_q <= 1'b0;
      end else begin
         ext_q      <= EXT_TICK;
         ext_prev_q <= ext_q;
      end
   end

   assign tick = presc_run && ext_q && !ext_prev_q;
`else
   logic presc_clear;

   assign presc_clear = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && START && !STOP;

   tick_prescaler #(.DIV(TICK_DIV)) u_prescaler (
      .CLK   (CLK),
      .RESET (RESET),
      .CLEAR (presc_clear),
      .RUN   (presc_run),
      .TICK  (tick)
   );
`endif

   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      count_en_d   = 1'b0;
      count_load_d = 1'b0;
      wrap_d       = 1'b0;
      count_up_d   = count_up_q;
      load_value_d = load_value_q;
      cfg_err_d    = cfg_err_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (START && !STOP) begin
               if (LIMIT_LO >= LIMIT_HI) begin
                  cfg_err_d = 1'b1;
               end else begin
                  cfg_err_d    = 1'b0;
                  mode_d       = MODE;
                  count_load_d = 1'b1;
                  load_value_d = (MODE == MODE_DOWN_WRAP) ? LIMIT_HI : LIMIT_LO;
                  count_up_d   = (MODE != MODE_DOWN_WRAP);
                  state_d      = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (STOP) begin
               state_d = ST_PAUSED;
            end else if (tick) begin
               if (!in_range) begin
                  count_load_d = 1'b1;
                  load_value_d = start_val;
                  count_up_d   = (mode_q != MODE_DOWN_WRAP);
               end else begin
                  case (mode_q)
                     MODE_UP_WRAP: begin
                        if (COUNT == LIMIT_HI) begin
                           count_load_d = 1'b1;
                           load_value_d = LIMIT_LO;
                           wrap_d       = 1'b1;
                        end else begin
                           count_en_d = 1'b1;
                        end
                     end
                     MODE_DOWN_WRAP: begin
                        if (COUNT == LIMIT_LO) begin
                           count_load_d = 1'b1;
                           load_value_d = LIMIT_HI;
                           wrap_d       = 1'b1;
                        end else begin
                           count_en_d = 1'b1;
                        end
                     end
                     MODE_PINGPONG: begin
                        // The turn-around step goes out with the new direction already applied.
                        count_en_d = 1'b1;
                        if (count_up_q && (COUNT == LIMIT_HI)) begin
                           count_up_d = 1'b0;
                           wrap_d     = 1'b1;
                        end else if (!count_up_q && (COUNT == LIMIT_LO)) begin
                           count_up_d = 1'b1;
                           wrap_d     = 1'b1;
                        end
                     end
                     default: begin
                        if (COUNT == LIMIT_HI) begin
                           wrap_d  = 1'b1;
                           state_d = ST_DONE;
                        end else begin
                           count_en_d = 1'b1;
                        end
                     end
                  endcase
               end
            end
         end
         default: begin
            if (STOP) begin
               state_d = ST_IDLE;
            end else if (START) begin
               state_d = ST_RUN;
            end
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q      <= ST_IDLE;
         mode_q       <= MODE_UP_WRAP;
         count_en_q   <= 1'b0;
         count_up_q   <= 1'b1;
         count_load_q <= 1'b0;
         load_value_q <= '0;
         wrap_q       <= 1'b0;
         cfg_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         count_en_q   <= count_en_d;
         count_up_q   <= count_up_d;
         count_load_q <= count_load_d;
         load_value_q <= load_value_d;
         wrap_q       <= wrap_d;
         cfg_err_q    <= cfg_err_d;
      end
   end

   assign COUNT_EN   = count_en_q;
   assign COUNT_UP   = count_up_q;
   assign COUNT_LOAD = count_load_q;
   assign LOAD_VALUE = load_value_q;
   assign STATE      = state_q;
   assign WRAP_PULSE = wrap_q;
   assign CFG_ERR    = cfg_err_q;

endmodule

// File: tb/tb_counter_controller.sv
// tb/tb_counter_controller.sv - self-checking bench for counter_controller with a closed-form model
module tb_counter_controller;

   localparam int W    = 16;
   localparam int TDIV = 4;

   logic         CLK = 1'b0;
   logic         RESET;
   logic         START;
   logic         STOP;
   logic [1:0]   MODE;
   logic [W-1:0] LIMIT_LO;
   logic [W-1:0] LIMIT_HI;
   logic [W-1:0] COUNT;
   logic         COUNT_EN;
   logic         COUNT_UP;
   logic         COUNT_LOAD;
   logic [W-1:0] LOAD_VALUE;
   logic [1:0]   STATE;
   logic         WRAP_PULSE;
   logic         CFG_ERR;

   int vectors     = 0;
   int miscompares = 0;

   counter_controller #(.WIDTH(W), .TICK_DIV(TDIV)) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .START      (START),
      .STOP       (STOP),
      .MODE       (MODE),
      .LIMIT_LO   (LIMIT_LO),
      .LIMIT_HI   (LIMIT_HI),
      .COUNT      (COUNT),
      .COUNT_EN   (COUNT_EN),
      .COUNT_UP   (COUNT_UP),
      .COUNT_LOAD (COUNT_LOAD),
      .LOAD_VALUE (LOAD_VALUE),
      .STATE      (STATE),
      .WRAP_PULSE (WRAP_PULSE),
      .CFG_ERR    (CFG_ERR)
   );

   always #5 CLK = ~CLK;

   // Counter datapath: LOAD beats EN, value moves one cycle after the strobe.
   always @(posedge CLK or posedge RESET) begin
      if (RESET)           COUNT <= '0;
      else if (COUNT_LOAD) COUNT <= LOAD_VALUE;
      else if (COUNT_EN)   COUNT <= COUNT_UP ? COUNT + 1'b1 : COUNT - 1'b1;
   end

   // Counter value after the k-th strobe of a run (k=0 is the preset load).
   function automatic int exp_val(input logic [1:0] m, input int lo, input int hi, input int k);
      int span;
      int p;
      span = hi - lo;
      case (m)
         2'b00:   return lo + (k % (span + 1));
         2'b01:   return hi - (k % (span + 1));
         2'b10: begin
            p = k % (2 * span);
            return (p <= span) ? lo + p : lo + 2 * span - p;
         end
         default: return (k <= span) ? lo + k : hi;
      endcase
   endfunction

   function automatic bit exp_up(input logic [1:0] m, input int lo, input int hi, input int k);
      if (m == 2'b01) return 1'b0;
      if (m != 2'b10 || k == 0) return 1'b1;
      return exp_val(m, lo, hi, k) > exp_val(m, lo, hi, k - 1);
   endfunction

   task automatic wait_event(input int budget, output int n, output bit timed_out);
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (!(COUNT_EN || COUNT_LOAD || WRAP_PULSE) && n < budget);
      timed_out = !(COUNT_EN || COUNT_LOAD || WRAP_PULSE);
   endtask

   task automatic go_idle;
      STOP = 1'b1;
      repeat (2) @(negedge CLK);
      STOP = 1'b0;
   endtask

   task automatic test_reset;
      RESET = 1'b1; START = 1'b0; STOP = 1'b0; MODE = 2'b00;
      LIMIT_LO = '0; LIMIT_HI = '0;
      repeat (2) @(negedge CLK);
      vectors++;
      if ({STATE, COUNT_EN, COUNT_LOAD, WRAP_PULSE, CFG_ERR, COUNT_UP, LOAD_VALUE} !== {2'd0, 4'b0000, 1'b1, 16'h0000}) begin
         miscompares++;
         $display("FAIL reset_state got st=%0d en=%b ld=%b wr=%b err=%b up=%b lv=%0h want st=0 en=0 ld=0 wr=0 err=0 up=1 lv=0",
                  STATE, COUNT_EN, COUNT_LOAD, WRAP_PULSE, CFG_ERR, COUNT_UP, LOAD_VALUE);
      end
      RESET = 1'b0;
      @(negedge CLK);
   endtask

   task automatic test_run_mode(input logic [1:0] m, input int lo, input int hi, input int nev);
      int n;
      bit to;
      bit ld;
      int span;
      logic [3:0] expv;
      logic [W-1:0] exp_lv;
      span = hi - lo;
      exp_lv = W'((m == 2'b01) ? hi : lo);
      MODE = m; LIMIT_LO = W'(lo); LIMIT_HI = W'(hi); START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      MODE = 2'($urandom);
      vectors++;
      if ({COUNT_EN, COUNT_LOAD, WRAP_PULSE, COUNT_UP, STATE, LOAD_VALUE} !== {3'b010, exp_up(m, lo, hi, 0), 2'd1, exp_lv}) begin
         miscompares++;
         $display("FAIL arm m=%0d got en/ld/wr/up=%b%b%b%b st=%0d lv=%0d want 010%b st=1 lv=%0d",
                  m, COUNT_EN, COUNT_LOAD, WRAP_PULSE, COUNT_UP, STATE, LOAD_VALUE, exp_up(m, lo, hi, 0), exp_lv);
      end
      for (int k = 1; k <= nev; k++) begin
         wait_event(3 * TDIV, n, to);
         vectors++;
         if (to || n != TDIV) begin
            miscompares++;
            $display("FAIL interval m=%0d k=%0d got %0d cycles (timeout=%0d) want %0d", m, k, n, to, TDIV);
            return;
         end
         vectors++;
         if (COUNT !== W'(exp_val(m, lo, hi, k - 1))) begin
            miscompares++;
            $display("FAIL count m=%0d k=%0d got %0d want %0d", m, k, COUNT, exp_val(m, lo, hi, k - 1));
         end
         ld = 1'b0;
         case (m)
            2'b00, 2'b01: begin
               ld   = (k % (span + 1)) == 0;
               expv = {!ld, ld, ld, exp_up(m, lo, hi, k)};
            end
            2'b10:   expv = {2'b10, exp_up(m, lo, hi, k) != exp_up(m, lo, hi, k - 1), exp_up(m, lo, hi, k)};
            default: expv = {k <= span, 1'b0, k == span + 1, 1'b1};
         endcase
         vectors++;
         if ({COUNT_EN, COUNT_LOAD, WRAP_PULSE, COUNT_UP} !== expv) begin
            miscompares++;
            $display("FAIL strobe m=%0d k=%0d got en/ld/wr/up=%b%b%b%b want %b",
                     m, k, COUNT_EN, COUNT_LOAD, WRAP_PULSE, COUNT_UP, expv);
         end
         if (ld) begin
            vectors++;
            if (LOAD_VALUE !== W'((m == 2'b01) ? hi : lo)) begin
               miscompares++;
               $display("FAIL wrap_load m=%0d k=%0d got %0d want %0d", m, k, LOAD_VALUE, (m == 2'b01) ? hi : lo);
            end
         end
         if (m == 2'b11 && k == span + 1) begin
            vectors++;
            if (STATE !== 2'd3) begin
               miscompares++;
               $display("FAIL oneshot_done got st=%0d want 3", STATE);
            end
            break;
         end
      end
   endtask

   task automatic test_oneshot;
      bit seen;
      go_idle;
      test_run_mode(2'b11, 7, 9, 3);
      seen = 1'b0;
      repeat (20) begin
         @(negedge CLK);
         seen |= COUNT_EN | COUNT_LOAD | WRAP_PULSE;
      end
      vectors++;
      if ({seen, STATE, COUNT} !== {1'b0, 2'd3, 16'd9}) begin
         miscompares++;
         $display("FAIL done_hold got strobe=%b st=%0d count=%0d want strobe=0 st=3 count=9", seen, STATE, COUNT);
      end
      test_run_mode(2'b11, 7, 9, 3);
   endtask

   task automatic test_pause;
      int n;
      int pre;
      bit to;
      bit seen;
      go_idle;
      MODE = 2'b00; LIMIT_LO = 16'd3; LIMIT_HI = 16'd5; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      wait_event(3 * TDIV, n, to);
      pre = $urandom_range(0, TDIV - 1);
      repeat (pre) @(negedge CLK);
      STOP = 1'b1;
      @(negedge CLK);
      STOP = 1'b0;
      seen = 1'b0;
      repeat (8) begin
         @(negedge CLK);
         seen |= COUNT_EN | COUNT_LOAD | WRAP_PULSE;
      end
      vectors++;
      if ({seen, STATE} !== {1'b0, 2'd2}) begin
         miscompares++;
         $display("FAIL paused got strobe=%b st=%0d want strobe=0 st=2", seen, STATE);
      end
      START = 1'b1;
      wait_event(3 * TDIV, n, to);
      START = 1'b0;
      vectors++;
      if (to || n != 1 + TDIV - pre || COUNT_EN !== 1'b1) begin
         miscompares++;
         $display("FAIL resume pre=%0d got %0d cycles en=%b want %0d cycles en=1", pre, n, COUNT_EN, 1 + TDIV - pre);
      end
      STOP = 1'b1;
      @(negedge CLK);
      STOP = 1'b0;
      vectors++;
      if (STATE !== 2'd2) begin
         miscompares++;
         $display("FAIL pause2 got st=%0d want 2", STATE);
      end
      START = 1'b1; STOP = 1'b1;
      @(negedge CLK);
      START = 1'b0; STOP = 1'b0;
      vectors++;
      if (STATE !== 2'd0) begin
         miscompares++;
         $display("FAIL abort got st=%0d want 0", STATE);
      end
   endtask

   task automatic test_cfg_err;
      go_idle;
      MODE = 2'b00; LIMIT_LO = 16'd10; LIMIT_HI = 16'd10; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      repeat (2) @(negedge CLK);
      vectors++;
      if ({CFG_ERR, STATE, COUNT_LOAD} !== {1'b1, 2'd0, 1'b0}) begin
         miscompares++;
         $display("FAIL cfg_err got err=%b st=%0d ld=%b want err=1 st=0 ld=0", CFG_ERR, STATE, COUNT_LOAD);
      end
      LIMIT_LO = 16'd0; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      vectors++;
      if ({CFG_ERR, STATE, COUNT_LOAD, LOAD_VALUE} !== {1'b0, 2'd1, 1'b1, 16'd0}) begin
         miscompares++;
         $display("FAIL cfg_clear got err=%b st=%0d ld=%b lv=%0d want err=0 st=1 ld=1 lv=0",
                  CFG_ERR, STATE, COUNT_LOAD, LOAD_VALUE);
      end
   endtask

   task automatic test_out_of_range;
      int n;
      bit to;
      go_idle;
      MODE = 2'b00; LIMIT_LO = 16'd100; LIMIT_HI = 16'd110; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      wait_event(3 * TDIV, n, to);
      LIMIT_LO = 16'd200; LIMIT_HI = 16'd210;
      wait_event(3 * TDIV, n, to);
      vectors++;
      if (to || {COUNT_EN, COUNT_LOAD, WRAP_PULSE, LOAD_VALUE} !== {3'b010, 16'd200}) begin
         miscompares++;
         $display("FAIL out_of_range got en/ld/wr=%b%b%b lv=%0d timeout=%0d want 010 lv=200",
                  COUNT_EN, COUNT_LOAD, WRAP_PULSE, LOAD_VALUE, to);
      end
      wait_event(3 * TDIV, n, to);
      vectors++;
      if (to || {COUNT, COUNT_EN} !== {16'd200, 1'b1}) begin
         miscompares++;
         $display("FAIL after_reload got count=%0d en=%b want count=200 en=1", COUNT, COUNT_EN);
      end
   endtask

   task automatic test_reset_midrun;
      int n;
      bit to;
      go_idle;
      MODE = 2'b01; LIMIT_LO = 16'd20; LIMIT_HI = 16'd30; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      wait_event(3 * TDIV, n, to);
      repeat (TDIV - 1) @(negedge CLK);
      #2 RESET = 1'b1;
      #1;
      vectors++;
      if ({STATE, COUNT_EN, COUNT_LOAD, COUNT_UP, CFG_ERR, WRAP_PULSE} !== {2'd0, 2'b00, 1'b1, 2'b00}) begin
         miscompares++;
         $display("FAIL reset_midrun got st=%0d en=%b ld=%b up=%b err=%b wr=%b want st=0 en=0 ld=0 up=1 err=0 wr=0",
                  STATE, COUNT_EN, COUNT_LOAD, COUNT_UP, CFG_ERR, WRAP_PULSE);
      end
      @(negedge CLK);
      RESET = 1'b0;
      repeat (2 * TDIV) @(negedge CLK);
      vectors++;
      if ({STATE, COUNT_EN, COUNT_LOAD} !== {2'd0, 2'b00}) begin
         miscompares++;
         $display("FAIL post_reset got st=%0d en=%b ld=%b want st=0 en=0 ld=0", STATE, COUNT_EN, COUNT_LOAD);
      end
   endtask

   task automatic test_random_runs;
      logic [1:0] m;
      int lo;
      int span;
      for (int i = 0; i < 6; i++) begin
         m    = 2'($urandom_range(0, 3));
         lo   = $urandom_range(0, 65000);
         span = $urandom_range(1, 5);
         go_idle;
         test_run_mode(m, lo, lo + span, (m == 2'b11) ? span + 1 : 2 * span + 3);
      end
   endtask

   initial begin
      test_reset;
      test_run_mode(2'b00, 3, 5, 6);
      go_idle;
      test_run_mode(2'b10, 0, 2, 6);
      go_idle;
      test_run_mode(2'b01, 40, 43, 9);
      go_idle;
      test_run_mode(2'b00, 65533, 65535, 7);
      test_oneshot;
      test_pause;
      test_cfg_err;
      test_out_of_range;
      test_random_runs;
      test_reset_midrun;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish, vectors=%0d miscompares=%0d", vectors, miscompares);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/counter_controller.md
Name: counter_controller

Overview:
- Sequencer for the 16-bit up/down counter datapath.
- Generates paced count-enable strobes, drives direction and preset load, and watches the counter value against programmable limits.
- Implements four run modes: up-wrap, down-wrap, ping-pong and one-shot.
- Sits between board buttons/switches and the counter instance; the counter datapath must give LOAD priority over EN.

Parameters:
- WIDTH, 16, width of the counter value, limits and load value.
- TICK_DIV, 100000, CLK cycles between COUNT_EN strobes while running; must be ≥2.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  level, sampled each cycle; arm from IDLE/DONE, or resume from PAUSED.
- STOP  in  1  level; pause from RUN, or abort from PAUSED.
- MODE  in  2  00 up-wrap, 01 down-wrap, 10 ping-pong, 11 one-shot up.
- LIMIT_LO  in  WIDTH  lower bound.
- LIMIT_HI  in  WIDTH  upper bound.
- COUNT  in  WIDTH  current counter value fed back from the datapath.
- COUNT_EN  out  1  one-cycle step strobe to the counter.
- COUNT_UP  out  1  direction: 1 = increment, 0 = decrement (the counter's CONTROL_SWITCH).
- COUNT_LOAD  out  1  one-cycle preset strobe.
- LOAD_VALUE  out  WIDTH  preset value; valid while COUNT_LOAD is high.
- STATE  out  2  IDLE=0, RUN=1, PAUSED=2, DONE=3.
- WRAP_PULSE  out  1  one cycle on every limit event (wrap, turn-around, one-shot finish).
- CFG_ERR  out  1  sticky misconfiguration flag.

Behaviour:
- Reset (asynchronous, any time including mid-run):
  - STATE=IDLE; COUNT_EN, COUNT_LOAD, WRAP_PULSE, CFG_ERR = 0.
  - COUNT_UP=1; LOAD_VALUE=0; prescaler=0; latched mode=00.
- All outputs are registered.
- START with STOP in the same cycle: STOP wins.
- IDLE or DONE, START=1:
  - If LIMIT_LO ≥ LIMIT_HI: CFG_ERR=1, remain in the current state.
  - Otherwise: CFG_ERR=0; latch MODE; next cycle COUNT_LOAD=1 for one cycle.
  - LOAD_VALUE = LIMIT_HI for mode 01, else LIMIT_LO.
  - COUNT_UP = 0 for mode 01, else 1.
  - Enter RUN; prescaler cleared.
- RUN:
  - Prescaler counts 0..TICK_DIV-1. On terminal count a tick occurs; the first tick is TICK_DIV cycles after entering RUN.
  - Tick with no boundary: COUNT_EN=1 for one cycle, COUNT_UP unchanged.
  - Up-wrap, tick at COUNT==LIMIT_HI: COUNT_LOAD with LIMIT_LO, no COUNT_EN, WRAP_PULSE.
  - Down-wrap, tick at COUNT==LIMIT_LO: COUNT_LOAD with LIMIT_HI, WRAP_PULSE.
  - Ping-pong, up at HI or down at LO: COUNT_UP toggles in the same cycle that COUNT_EN steps in the new direction; WRAP_PULSE.
  - One-shot, tick at COUNT==LIMIT_HI: no step, WRAP_PULSE, enter DONE.
  - Boundary comparisons use equality. If COUNT lies outside [LO,HI] (limits changed mid-run), the next tick forces COUNT_LOAD with the mode's start value, without WRAP_PULSE.
  - STOP=1: enter PAUSED; prescaler holds its value; no further strobes.
  - MODE changes are ignored while in RUN.
- PAUSED:
  - START: return to RUN, prescaler resumes from its held value, no load.
  - STOP (held on a later cycle): abort to IDLE.
- DONE: no strobes; COUNT holds at LIMIT_HI; only START or RESET leaves this state.
- Latency: the counter reflects a strobe one cycle after it. Because TICK_DIV ≥ 2, COUNT is always current at the next tick.

Optional Feature:
- Macro: COUNTER_CTRL_EXT_TICK_EN.
- When defined:
  - Adds input EXT_TICK (1 bit).
  - The internal prescaler is removed.
  - A tick is a registered rising edge of EXT_TICK, detected while in RUN.
  - Edges seen while PAUSED are discarded.
- When undefined: no EXT_TICK port; ticks come from the TICK_DIV prescaler.

Decomposition:
- Package counter_ctrl_pkg:
  - State encodings (IDLE, RUN, PAUSED, DONE).
  - MODE constants (MODE_UP_WRAP, MODE_DOWN_WRAP, MODE_PINGPONG, MODE_ONESHOT).
  - Default WIDTH.
- Sub-module tick_prescaler:
  - Ports: CLK, RESET, CLEAR, RUN, TICK.
  - Parameter: DIV.
  - Holds its count when RUN=0.

Test Plan (TICK_DIV=4, WIDTH=16):
- Reset mid-RUN with COUNT_EN pending -> same cycle: STATE=0, COUNT_EN=0, COUNT_LOAD=0, COUNT_UP=1, CFG_ERR=0.
- MODE=00, LO=3, HI=5, START -> LOAD 3, then COUNT 4, 5, then LOAD 3 with WRAP_PULSE; strobes 4 cycles apart.
- MODE=10, LO=0, HI=2 -> COUNT 0,1,2,1,0,1; COUNT_UP drops at COUNT=2 and rises at COUNT=0; WRAP_PULSE at each turn.
- MODE=11, LO=7, HI=9 -> COUNT 8, 9, then STATE=DONE, no further COUNT_EN for 20 cycles; START restarts with LOAD 7.
- MODE=00, RUN, STOP held 1 cycle mid-period -> PAUSED, no strobes; START resumes and the next tick arrives after the remaining prescaler cycles. START+STOP together while PAUSED -> IDLE.
- LO=10, HI=10, START -> CFG_ERR=1, STATE stays IDLE, no COUNT_LOAD; then LO=0, START -> CFG_ERR=0 and LOAD 0.
